// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, per-round shifts, FSM states.
// Latency: n/a (constants and pure combinational helper functions only).
// Backpressure: n/a.
//
// Tables hold DES bit numbers (1 = MSB) exactly as printed in FIPS 46-3, so
// the helpers convert with vector[W - tableEntry].
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int KEY_W      = 64;
  localparam int SUBKEY_W   = 48;
  localparam int HALF_W     = 28;
  localparam int CD_W       = 2 * HALF_W;

  localparam int PC1_TABLE [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount applied before PC-2 for encrypt emission index i.
  localparam logic [1:0] ENC_SHIFT [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } desState_t;

  // PC-1: drops the eight parity bits and returns {C0, D0}.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] keyIn);
    logic [CD_W-1:0] res;
    res = '0;
    for (int i = 0; i < CD_W; i++) begin
      res[CD_W-1-i] = keyIn[KEY_W-PC1_TABLE[i]];
    end
    return res;
  endfunction

  // Rotate one 28-bit half by 0, 1 or 2 places, left or right.
  function automatic logic [HALF_W-1:0] rotHalf(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        amt,
                                                input logic              right);
    logic [HALF_W-1:0] res;
    case (amt)
      2'd1:    res = right ? {x[0], x[HALF_W-1:1]} : {x[HALF_W-2:0], x[HALF_W-1]};
      2'd2:    res = right ? {x[1:0], x[HALF_W-1:2]} : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      default: res = x;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// PC-2 permutation: 56-bit {C,D} to 48-bit DES round key.
// Latency: purely combinational.
// Backpressure: none, no state.
//
// Ports: cd     - {C, D}, DES bit 1 at cd[55]
//        subkey - PC-2 output, DES bit 1 at subkey[47]
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[SUBKEY_W-1-i] = cd[CD_W-PC2_TABLE[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator, one 48-bit round key per valid/ready transfer.
// Latency: start edge -> LOAD -> first key valid one edge later; then 1 key/cycle.
// Backpressure: subkey/round_idx/C/D hold while subkey_valid && !subkey_ready.
//
// Ports: clk, rst (sync, active high); key/decrypt/start request a schedule
//        when busy=0; subkey/subkey_valid/subkey_ready/round_idx form the
//        output stream; busy spans the whole schedule, done pulses at the end.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_W-1:0]    key,
  input  logic                decrypt,
  input  logic                start,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done
);

  desState_t         state, nextState;
  logic [HALF_W-1:0] cReg, dReg;
  logic [HALF_W-1:0] cNext, dNext;
  logic              decReg;
  logic [3:0]        stepIdx;
  logic [3:0]        shiftSel;
  logic [1:0]        rotAmt;
  logic [SUBKEY_W-1:0] pc2Out;
  logic              xfer;

  assign xfer = (state == EMIT) && subkey_ready;

  // Rotation for the key about to be registered. Decrypt walks the encrypt
  // schedule backwards: emission n undoes encrypt shift (16-n), and index 0
  // needs no rotation because the encrypt shifts total a full 28 places.
  always_comb begin
    stepIdx  = (state == EMIT) ? round_idx + 4'd1 : 4'd0;
    shiftSel = decReg ? 4'd0 - stepIdx : stepIdx;
    rotAmt   = ENC_SHIFT[shiftSel];
    if (decReg && (stepIdx == 4'd0)) begin
      rotAmt = 2'd0;
    end
    cNext = rotHalf(cReg, rotAmt, decReg);
    dNext = rotHalf(dReg, rotAmt, decReg);
  end

  des_pc2_perm uPc2 (
    .cd     ({cNext, dNext}),
    .subkey (pc2Out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    subkey_valid = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          nextState = LOAD;
        end
      end
      LOAD: nextState = EMIT;
      EMIT: begin
        subkey_valid = 1'b1;
        if (xfer && (round_idx == 4'd15)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cReg      <= '0;
      dReg      <= '0;
      decReg    <= 1'b0;
      subkey    <= '0;
      round_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            {cReg, dReg} <= pc1(key);
            decReg       <= decrypt;
            round_idx    <= 4'd0;
          end
        end
        LOAD: begin
          cReg   <= cNext;
          dReg   <= dNext;
          subkey <= pc2Out;
        end
        EMIT: begin
          if (xfer && (round_idx != 4'd15)) begin
            cReg      <= cNext;
            dReg      <= dNext;
            subkey    <= pc2Out;
            round_idx <= round_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key;
  logic        decrypt;
  logic        start;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int nChecks = 0;
  int nFails  = 0;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .decrypt      (decrypt),
    .start        (start),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference tables straight from the DES standard (bit 1 = MSB).
  localparam int PC1 [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,
    19,11, 3,60,52,44,36,63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2 [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,
    16, 7,27,20,13, 2,41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] expK [16];
  logic [47:0] got [$];
  int          gotIdx [$];
  logic [47:0] encSeq [16];
  int          lastCycles;

  // Textbook schedule: K_r = PC2(C0,D0 rotated left by cumulative shift r);
  // decrypt order is simply the encrypt list reversed.
  function automatic void modelSchedule(input logic [63:0] k, input logic dec);
    logic        cd [56];
    logic [47:0] ks [16];
    int          cum, pos, half, off;
    for (int j = 0; j < 56; j++) cd[j] = k[64 - PC1[j]];
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += SHIFTS[r];
      ks[r] = '0;
      for (int n = 0; n < 48; n++) begin
        pos  = PC2[n] - 1;
        half = pos / 28;
        off  = pos % 28;
        ks[r][47-n] = cd[half*28 + (off + cum) % 28];
      end
    end
    for (int r = 0; r < 16; r++) expK[r] = dec ? ks[15-r] : ks[r];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: ready=1; mode 1: random ready with 5-cycle stall at index 7;
  // mode 2: ready=1 with ignored start pulses at index 3 and during DONE.
  task automatic runSchedule(input logic [63:0] k, input logic dec, input int mode);
    logic [47:0] holdK;
    logic [3:0]  holdI;
    logic        stalled, xferNow, finished, pulsed3;
    int          cyc, stallCnt;
    got.delete();
    gotIdx.delete();
    key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = ~k; decrypt = ~dec;
    check("busy after start", 64'(busy), 64'd1);
    check("valid low in LOAD", 64'(subkey_valid), 64'd0);
    @(posedge clk); #1;
    check("first valid", 64'(subkey_valid), 64'd1);
    cyc = 0; stallCnt = 0; finished = 1'b0; pulsed3 = 1'b0;
    while (!finished && cyc < 300) begin
      if (mode == 1) begin
        if (subkey_valid && round_idx == 4'd7 && stallCnt < 5) begin
          subkey_ready = 1'b0;
          stallCnt++;
        end else begin
          subkey_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        subkey_ready = 1'b1;
      end
      if (mode == 2 && subkey_valid && round_idx == 4'd3 && !pulsed3) begin
        start = 1'b1;
        pulsed3 = 1'b1;
      end
      xferNow = subkey_valid && subkey_ready;
      if (xferNow) begin
        got.push_back(subkey);
        gotIdx.push_back(int'(round_idx));
      end
      holdK = subkey; holdI = round_idx;
      stalled = subkey_valid && !subkey_ready;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (stalled) begin
        check("stall subkey", 64'(subkey), 64'(holdK));
        check("stall idx", 64'(round_idx), 64'(holdI));
        check("stall valid", 64'(subkey_valid), 64'd1);
      end
      if (xferNow && got.size() == 16) finished = 1'b1;
    end
    lastCycles = cyc;
    check("transfers", 64'(got.size()), 64'd16);
    if (finished) begin
      check("done pulse", 64'(done), 64'd1);
      check("valid in DONE", 64'(subkey_valid), 64'd0);
      if (mode == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done one cycle", 64'(done), 64'd0);
      check("idle after done", 64'(busy), 64'd0);
      check("subkey held", 64'(subkey), 64'(got[15]));
      modelSchedule(k, dec);
      for (int i = 0; i < 16; i++) begin
        check($sformatf("idx[%0d]", i), 64'(gotIdx[i]), 64'(i));
        check($sformatf("subkey[%0d]", i), 64'(got[i]), 64'(expK[i]));
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [63:0] k;
    logic        dec;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    vecs[2] = '{64'h0000000000000000, 1'b0, 48'h0, 48'h0};
    vecs[3] = '{64'h0101010101010101, 1'b0, 48'h0, 48'h0};
    vecs[4] = '{64'h0101010101010101, 1'b1, 48'h0, 48'h0};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

    rst = 1'b1; start = 1'b0; key = '0; decrypt = 1'b0; subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset subkey", 64'(subkey), 64'd0);
    check("reset valid", 64'(subkey_valid), 64'd0);
    check("reset idx", 64'(round_idx), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      runSchedule(vecs[v].k, vecs[v].dec, 0);
      if (got.size() == 16) begin
        check($sformatf("vec%0d first", v), 64'(got[0]), 64'(vecs[v].first));
        check($sformatf("vec%0d last", v), 64'(got[15]), 64'(vecs[v].last));
        check($sformatf("vec%0d cycles", v), 64'(lastCycles), 64'd16);
        for (int i = 0; i < 16; i++) begin
          if (v == 0) encSeq[i] = got[i];
          else if (v == 1) check($sformatf("reverse[%0d]", i), 64'(got[i]), 64'(encSeq[15-i]));
          else if (v >= 2) check($sformatf("vec%0d const[%0d]", v, i), 64'(got[i]), 64'(vecs[v].first));
        end
      end
    end

    for (int t = 0; t < 4; t++) begin
      runSchedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
    end

    runSchedule(64'h133457799BBCDFF1, 1'b0, 1);
    runSchedule(64'h133457799BBCDFF1, 1'b0, 2);

    // Reset mid-schedule, with a start in the same cycle that must be lost.
    key = 64'h0E329232EA6D0D73; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int w;
      w = 0;
      while (!(subkey_valid && round_idx == 4'd9) && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      check("reach idx9", 64'(w < 50), 64'd1);
    end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("mid rst subkey", 64'(subkey), 64'd0);
    check("mid rst valid", 64'(subkey_valid), 64'd0);
    check("mid rst idx", 64'(round_idx), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("start with rst lost", 64'(busy), 64'd0);
    runSchedule(64'hA5C3F00F12345678, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES subkey generator that sits directly upstream of the DES round datapath and feeds it one 48-bit round key per handshake.
- Takes the 64-bit key once, applies PC-1, then iterates the C/D rotations and PC-2 over 16 rounds.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) without storing all 16 subkeys.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted. Fixed by DES; any other value is unsupported.
- KEY_W, 64, input key width, including the 8 ignored parity bits.
- SUBKEY_W, 48, PC-2 output width.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- key  input  64  DES key. DES bit 1 is key[63]. Sampled only when start is accepted.
- decrypt  input  1  0 gives K1..K16, 1 gives K16..K1. Sampled with key.
- start  input  1  request a new schedule. Accepted only when busy=0.
- subkey  output  48  current round key. DES bit 1 is subkey[47].
- subkey_valid  output  1  subkey and round_idx are valid.
- subkey_ready  input  1  consumer accepts. Transfer happens when valid and ready are both high at a rising edge.
- round_idx  output  4  index of the emitted subkey in emission order, 0..15.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the 16th transfer.

Behaviour:
- Reset (sync, highest priority, also mid-schedule): state=IDLE; subkey=0, subkey_valid=0, round_idx=0, busy=0, done=0; C=D=0.
- States and transitions:
  - IDLE: on start, latch C0/D0 = PC-1(key) halves (28b each) and latch decrypt; go to LOAD.
  - LOAD: compute the first subkey; go to EMIT.
  - EMIT: hold subkey_valid=1.
    - On a transfer with round_idx<15: rotate C/D, register the next subkey, increment round_idx. Valid stays high, so there are no bubbles.
    - On a transfer with round_idx=15: go to DONE.
  - DONE: done=1, subkey_valid=0; go to IDLE on the next cycle.
- Latency: start sampled at edge E0, then LOAD at E1, then the first subkey_valid=1 after E2. With ready held high, 16 subkeys appear on 16 consecutive cycles, and done pulses the cycle after the last transfer.
- Backpressure: while valid=1 and ready=0, subkey, round_idx and C/D hold stable. ready is ignored when valid=0.
- Encrypt rotation: before PC-2 for emission index i, rotate C and D left by 1 when i∈{0,1,8,15}, otherwise by 2. Cumulative rotation is 28.
- Decrypt rotation: index 0 uses C0/D0 unrotated, which gives K16. Indices 1, 8 and 15 rotate right by 1; all other indices rotate right by 2.
- Rotations are modulo 28 on each half independently. C never mixes into D.
- Parity bits (DES bits 8,16,...,64) never affect any output.
- start while busy=1 (including LOAD and DONE) is ignored, with no queuing. start in the same cycle as rst is lost.
- subkey keeps its last value after DONE, with valid=0.

Decomposition:
- Shared package des_pkg:
  - PC1_TABLE (56 entries)
  - PC2_TABLE (48 entries)
  - ENC_SHIFT (16 × 2-bit rotation amounts)
  - the state enum
  - width constants
- One combinational sub-module, des_pc2_perm, maps the 56-bit {C,D} to the 48-bit subkey. It is reused by the round datapath bench.

Test Plan:
- Key 64'h133457799BBCDFF1, decrypt=0, ready=1 → first valid after E2. round_idx 0 gives 48'h1B02EFFC7072; round_idx 15 gives 48'hCB3D8B0E17F5. 16 consecutive valid cycles, done pulses once.
- Same key, decrypt=1 → round_idx 0 gives 48'hCB3D8B0E17F5, round_idx 15 gives 48'h1B02EFFC7072. The full sequence is the exact reverse of the encrypt run.
- Keys 64'h0000000000000000 and 64'h0101010101010101 → all 16 subkeys are 48'h0, confirming parity is ignored. Key 64'hFFFFFFFFFFFFFFFF → all 16 subkeys are 48'hFFFFFFFFFFFF.
- Backpressure: ready driven with a random pattern, held low 5 cycles at round_idx 7 → subkey and round_idx stable while stalled. The sequence matches the ready=1 run and the total transfer count is 16.
- Second start pulsed at round_idx 3 and again during DONE → both ignored, with no change to the sequence or done timing.
- rst asserted at round_idx 9 → the next cycle shows all outputs 0 and busy=0. A following start with a new key produces the correct full schedule from round_idx 0.
